// File: rtl/mnist_frame_sequencer.sv
// Host-side frame sequencer for the MNIST core: streams one image into the
// image buffer, kicks the network, waits for its answer and returns the digit.
module mnist_frame_sequencer #(
    parameter int NUM_PIXELS     = 784,
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              net_start,
    input  logic              net_done,
    input  logic [15:0]       net_prediction,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_digit,
    output logic              res_error,
    output logic              busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {LOAD, DRAIN, START, WAIT, RESULT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [3:0]          res_digit_q, res_digit_d;
    logic                res_error_q, res_error_d;
    logic                s_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                accept;

    assign accept = s_valid && s_ready_q;

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        timer_d     = timer_q;
        res_digit_d = res_digit_q;
        res_error_d = res_error_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == LAST_PIX) begin
                        if (s_last) begin
                            state_d = START;
                        end else begin
                            state_d     = DRAIN;
                            res_digit_d = 4'hF;
                            res_error_d = 1'b1;
                        end
                    end else if (s_last) begin
                        state_d     = RESULT;
                        res_digit_d = 4'hF;
                        res_error_d = 1'b1;
                    end
                end
            end
            // error already latched on entry; just swallow the overlong tail
            DRAIN: begin
                if (accept && s_last) state_d = RESULT;
            end
            START: begin
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: begin
                if (net_done) begin
                    state_d = RESULT;
                    if (net_prediction <= 16'd9) begin
                        res_digit_d = net_prediction[3:0];
                        res_error_d = 1'b0;
                    end else begin
                        res_digit_d = 4'hF;
                        res_error_d = 1'b1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    state_d     = RESULT;
                    res_digit_d = 4'hF;
                    res_error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d   = LOAD;
                    pix_cnt_d = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            pix_cnt_q   <= '0;
            timer_q     <= '0;
            res_digit_q <= '0;
            res_error_q <= 1'b0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            timer_q     <= timer_d;
            res_digit_q <= res_digit_d;
            res_error_q <= res_error_d;
            // registered decode of the next state keeps s_ready free of input paths
            s_ready_q   <= (state_d == LOAD) || (state_d == DRAIN);
            mem_we_q    <= accept && (state_q == LOAD);
            if (accept && (state_q == LOAD)) begin
                mem_addr_q  <= pix_cnt_q;
                mem_wdata_q <= s_data;
            end
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign net_start = (state_q == START);
    assign res_valid = (state_q == RESULT);
    assign res_digit = res_digit_q;
    assign res_error = res_error_q;
    assign busy      = !((state_q == LOAD) && (pix_cnt_q == '0));
endmodule

// File: tb/tb_mnist_frame_sequencer.sv
// Directed + randomized bench for mnist_frame_sequencer against a frame-level
// reference model (expected writes, start count, result digit and latency).
module tb_mnist_frame_sequencer;
    localparam int NUM = 784;
    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          mem_we, net_start, net_done = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [15:0]   net_prediction = '0;
    logic          res_valid, res_ready = 1'b0, res_error, busy;
    logic [3:0]    res_digit;

    mnist_frame_sequencer #(.NUM_PIXELS(NUM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .net_start(net_start), .net_done(net_done), .net_prediction(net_prediction),
        .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit),
        .res_error(res_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    logic [DW-1:0] fd[$];
    int   last_wr_cyc = 0, n_start = 0, rv_cyc = 0;
    logic rv_prev = 1'b0;

    // passive observer of the buffer port, start pulses and result rise time
    always @(negedge clk) begin
        if (!rst_n) begin
            rv_prev = 1'b0;
        end else begin
            if (mem_we) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
                last_wr_cyc = cyc;
            end
            if (net_start) n_start++;
            if (res_valid && !rv_prev) rv_cyc = cyc;
            rv_prev = res_valid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        wa.delete(); wd.delete(); fd.delete();
        n_start = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_net_start"}, net_start, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_digit"}, res_digit, 0);
        chk({tag, "_res_error"}, res_error, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (!s_ready && g < 200) begin @(negedge clk); g++; end
        if (!s_ready) chk("s_ready_wait", s_ready, 1);
    endtask

    task automatic send_beats(input int n, input int last_idx, input bit idx_data);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin s_valid = 1'b0; @(posedge clk); #1; end
            d = idx_data ? DW'(i) : DW'($urandom);
            fd.push_back(d);
            s_valid = 1'b1; s_data = d; s_last = (i == last_idx);
            wait_ready();
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_start(output int sc);
        int g = 0;
        @(negedge clk);
        while (!net_start && g < 20) begin @(negedge clk); g++; end
        sc = cyc;
        chk("net_start_seen", net_start, 1);
    endtask

    task automatic wait_res(input int bound);
        int g = 0;
        @(negedge clk);
        while (!res_valid && g < bound) begin @(negedge clk); g++; end
        chk("res_valid_seen", res_valid, 1);
        #1;
    endtask

    task automatic pulse_done(input logic [15:0] pred);
        net_prediction = pred; net_done = 1'b1;
        @(posedge clk); #1;
        net_done = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("res_valid_after_hs", res_valid, 0);
        chk("s_ready_after_hs", s_ready, 1);
        chk("busy_after_hs", busy, 0);
    endtask

    // beats already sent; the model decides from last_idx alone what must follow
    task automatic finish_frame(input int last_idx, input int dly, input logic [15:0] pred, input bit hs);
        int sc, expn, mis;
        bit good;
        good = (last_idx == NUM - 1);
        if (good) begin
            wait_start(sc);
            repeat (dly) @(posedge clk);
            #1;
            pulse_done(pred);
            wait_res(20);
            if (dly <= TMO) begin
                chk("digit", res_digit, (pred <= 9) ? pred[3:0] : 4'hF);
                chk("error", res_error, (pred > 9) ? 1 : 0);
                chk("done_latency", rv_cyc, sc + dly + 1);
            end else begin
                chk("tmo_digit", res_digit, 4'hF);
                chk("tmo_error", res_error, 1);
                chk("tmo_latency", rv_cyc, sc + 1 + TMO);
            end
            chk("start_after_last_wr", (sc >= last_wr_cyc && sc <= last_wr_cyc + 1) ? 1 : 0, 1);
        end else begin
            wait_res(2000);
            chk("len_err_digit", res_digit, 4'hF);
            chk("len_err_error", res_error, 1);
        end
        chk("n_start", n_start, good ? 1 : 0);
        expn = (last_idx + 1 < NUM) ? last_idx + 1 : NUM;
        chk("wr_count", wa.size(), expn);
        mis = 0;
        for (int i = 0; i < wa.size() && i < expn; i++)
            if (wa[i] !== AW'(i) || wd[i] !== fd[i]) mis++;
        chk("wr_data", mis, 0);
        chk("s_ready_in_result", s_ready, 0);
        chk("busy_in_result", busy, 1);
        if (hs) handshake();
    endtask

    initial begin
        int sc, mis, kind, li;
        logic [3:0] d0;
        // reset state
        #12;
        check_reset("rst");
        @(negedge clk); rst_n = 1'b1;

        // good frame, data = index, prediction 7 after 50 cycles
        clear_model();
        send_beats(NUM, NUM - 1, 1'b1);
        finish_frame(NUM - 1, 50, 16'd7, 1'b0);

        // result held while host stalls
        d0 = res_digit; mis = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_digit !== d0 || res_error !== 1'b0 || s_ready !== 1'b0) mis++;
        end
        chk("hold_stable", mis, 0);
        handshake();

        // short frame
        clear_model();
        send_beats(100, 99, 1'b0);
        finish_frame(99, 0, 16'd0, 1'b1);

        // overlong frame
        clear_model();
        send_beats(790, 789, 1'b0);
        finish_frame(789, 0, 16'd0, 1'b1);

        // timeout, with a late done that must be ignored
        clear_model();
        send_beats(NUM, NUM - 1, 1'b0);
        finish_frame(NUM - 1, 101, 16'd3, 1'b0);
        repeat (3) @(negedge clk);
        chk("late_done_digit", res_digit, 4'hF);
        chk("late_done_error", res_error, 1);
        handshake();

        // out-of-range prediction
        clear_model();
        send_beats(NUM, NUM - 1, 1'b0);
        finish_frame(NUM - 1, 20, 16'd12, 1'b1);

        // done on the timeout cycle wins
        clear_model();
        send_beats(NUM, NUM - 1, 1'b0);
        finish_frame(NUM - 1, TMO, 16'd5, 1'b1);

        // randomized frames
        for (int k = 0; k < 4; k++) begin
            kind = $urandom_range(0, 2);
            li = (kind == 0) ? NUM - 1 : (kind == 1) ? $urandom_range(0, NUM - 2) : $urandom_range(NUM, NUM + 5);
            clear_model();
            send_beats(li + 1, li, 1'b0);
            finish_frame(li, $urandom_range(1, 105), 16'($urandom_range(0, 15)), 1'b1);
        end

        // reset mid-frame
        clear_model();
        send_beats(400, 1000, 1'b0);
        s_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid_frame");
        s_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        clear_model();
        send_beats(NUM, NUM - 1, 1'b0);
        finish_frame(NUM - 1, 30, 16'd9, 1'b1);

        // reset mid-inference, then a stale done
        clear_model();
        send_beats(NUM, NUM - 1, 1'b0);
        wait_start(sc);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid_wait");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_done(16'd4);
        repeat (3) @(negedge clk);
        chk("stale_done_res_valid", res_valid, 0);
        chk("stale_done_busy", busy, 0);
        chk("stale_done_s_ready", s_ready, 1);
        clear_model();
        send_beats(NUM, NUM - 1, 1'b0);
        finish_frame(NUM - 1, 15, 16'd2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
